// File: rtl/hog_orient_bin.sv
// Four-stage HOG orientation binning: folds signed dx/dy into a quadrant, picks the
// nearest 20-degree bin centre (18 signed / 9 unsigned bins) and reports the L1 magnitude.
module hog_orient_bin #(
  parameter int DATA_W = 16,
  parameter int QN     = 8,
  parameter int USER_W = 8
) (
  input  logic                     aclk,
  input  logic                     arest,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_dx,
  input  logic signed [DATA_W-1:0] s_dy,
  input  logic                     s_signed,
  input  logic [USER_W-1:0]        s_user,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [4:0]               m_bin,
  output logic [DATA_W:0]          m_mag,
  output logic                     m_zero,
  output logic [USER_W-1:0]        m_user
);

  localparam int DW = DATA_W + QN + 1;
  localparam int CW = QN + 1;

  function automatic int roundCoef(input int c14);
    int sh;
    sh = 14 - QN;
    if (sh == 0) return c14;
    return (c14 + (1 << (sh - 1))) >> sh;
  endfunction

  // Direction vectors for the five bin centres 0..80 degrees inside one quadrant.
  localparam logic [CW-1:0] COS_K [5] = '{CW'(roundCoef(16384)), CW'(roundCoef(15396)),
                                          CW'(roundCoef(12551)), CW'(roundCoef(8192)),
                                          CW'(roundCoef(2845))};
  localparam logic [CW-1:0] SIN_K [5] = '{CW'(roundCoef(0)),     CW'(roundCoef(5604)),
                                          CW'(roundCoef(10531)), CW'(roundCoef(14189)),
                                          CW'(roundCoef(16135))};

  logic en;

  logic              v1_q, sgn1_q, zero1_q;
  logic [DATA_W-1:0] ax1_q, ay1_q;
  logic [1:0]        quad1_q;
  logic [USER_W-1:0] user1_q;

  logic              v2_q, sgn2_q, zero2_q;
  logic [DW-1:0]     dot2_q [5];
  logic [DATA_W:0]   mag2_q;
  logic [1:0]        quad2_q;
  logic [USER_W-1:0] user2_q;

  logic              v3_q, sgn3_q, zero3_q;
  logic [2:0]        k3_q;
  logic [DATA_W:0]   mag3_q;
  logic [1:0]        quad3_q;
  logic [USER_W-1:0] user3_q;

  logic              v4_q, zero4_q;
  logic [4:0]        bin4_q;
  logic [DATA_W:0]   mag4_q;
  logic [USER_W-1:0] user4_q;

  logic [DATA_W-1:0] ax_d, ay_d;
  logic [1:0]        quad_d;
  logic              zero_d;
  logic [DW-1:0]     dot_d [5];
  logic [DATA_W:0]   mag_d;
  logic [DW-1:0]     best;
  logic [2:0]        k_d;
  logic [4:0]        bin_d;

  assign en      = !v4_q || m_ready;
  assign s_ready = en;
  assign m_valid = v4_q;
  assign m_bin   = bin4_q;
  assign m_mag   = mag4_q;
  assign m_zero  = zero4_q;
  assign m_user  = user4_q;

  // Dx == 0 with dy < 0 belongs to Q2 so that 270 degrees lands on bin 13.
  always_comb begin
    ax_d   = s_dx[DATA_W-1] ? (~s_dx + 1'b1) : s_dx;
    ay_d   = s_dy[DATA_W-1] ? (~s_dy + 1'b1) : s_dy;
    zero_d = (s_dx == '0) && (s_dy == '0);
    if (!s_dy[DATA_W-1]) quad_d = s_dx[DATA_W-1] ? 2'd0 + 2'd1 : 2'd0;
    else                 quad_d = (s_dx[DATA_W-1] || s_dx == '0) ? 2'd2 : 2'd3;
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      dot_d[k] = DW'(ax1_q) * DW'(COS_K[k]) + DW'(ay1_q) * DW'(SIN_K[k]);
    end
    mag_d = {1'b0, ax1_q} + {1'b0, ay1_q};
  end

  // Mirrored quadrants (Q1/Q3) prefer the higher k so every tie lands on the lower bin.
  always_comb begin
    best = dot2_q[0];
    k_d  = 3'd0;
    for (int k = 1; k < 5; k++) begin
      if (dot2_q[k] > best || (quad2_q[0] && dot2_q[k] == best)) begin
        best = dot2_q[k];
        k_d  = 3'(k);
      end
    end
  end

  always_comb begin
    case (quad3_q)
      2'd0:    bin_d = 5'(k3_q);
      2'd1:    bin_d = 5'd9 - 5'(k3_q);
      2'd2:    bin_d = 5'd9 + 5'(k3_q);
      default: bin_d = (k3_q == 3'd0) ? 5'd0 : 5'd18 - 5'(k3_q);
    endcase
    if (!sgn3_q && bin_d >= 5'd9) bin_d = bin_d - 5'd9;
    if (zero3_q) bin_d = 5'd0;
  end

  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      v1_q <= 1'b0; sgn1_q <= 1'b0; zero1_q <= 1'b0; ax1_q <= '0; ay1_q <= '0;
      quad1_q <= '0; user1_q <= '0;
      v2_q <= 1'b0; sgn2_q <= 1'b0; zero2_q <= 1'b0; mag2_q <= '0; quad2_q <= '0;
      user2_q <= '0;
      for (int k = 0; k < 5; k++) dot2_q[k] <= '0;
      v3_q <= 1'b0; sgn3_q <= 1'b0; zero3_q <= 1'b0; k3_q <= '0; mag3_q <= '0;
      quad3_q <= '0; user3_q <= '0;
      v4_q <= 1'b0; zero4_q <= 1'b0; bin4_q <= '0; mag4_q <= '0; user4_q <= '0;
    end else if (en) begin
      v1_q <= s_valid; sgn1_q <= s_signed; zero1_q <= zero_d; ax1_q <= ax_d;
      ay1_q <= ay_d; quad1_q <= quad_d; user1_q <= s_user;
      v2_q <= v1_q; sgn2_q <= sgn1_q; zero2_q <= zero1_q; mag2_q <= mag_d;
      quad2_q <= quad1_q; user2_q <= user1_q;
      for (int k = 0; k < 5; k++) dot2_q[k] <= dot_d[k];
      v3_q <= v2_q; sgn3_q <= sgn2_q; zero3_q <= zero2_q; k3_q <= k_d;
      mag3_q <= mag2_q; quad3_q <= quad2_q; user3_q <= user2_q;
      v4_q <= v3_q; zero4_q <= zero3_q; bin4_q <= bin_d; mag4_q <= mag3_q;
      user4_q <= user3_q;
    end
  end

endmodule

// File: tb/tb_hog_orient_bin.sv
// Scoreboard bench for hog_orient_bin: a QN=8 and a QN=14 instance share stimulus and
// handshake, and every output beat is checked against an angle-level reference model.
module tb_hog_orient_bin;

  localparam int DATA_W = 16;
  localparam int USER_W = 8;

  logic                     aclk = 1'b0;
  logic                     arest;
  logic                     s_valid, s_signed;
  logic signed [DATA_W-1:0] s_dx, s_dy;
  logic [USER_W-1:0]        s_user;
  logic                     m_ready;
  logic                     s_ready, m_valid, m_zero;
  logic [4:0]               m_bin;
  logic [DATA_W:0]          m_mag;
  logic [USER_W-1:0]        m_user;
  logic                     s_ready14, m_valid14, m_zero14;
  logic [4:0]               m_bin14;
  logic [DATA_W:0]          m_mag14;
  logic [USER_W-1:0]        m_user14;

  typedef struct {
    int    bin8;
    int    bin14;
    int    mag;
    int    zero;
    int    user;
    int    cyc;
    bit    chkLat;
    string tag;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   readyMode = 0;
  int   patCnt = 0;
  bit   started = 0;
  bit   haveSnap = 0;
  int   snapBin, snapMag, snapZero, snapUser;
  int   userCnt = 0;

  hog_orient_bin #(.DATA_W(DATA_W), .QN(8), .USER_W(USER_W)) u_dut8 (
    .aclk(aclk), .arest(arest), .s_valid(s_valid), .s_ready(s_ready), .s_dx(s_dx),
    .s_dy(s_dy), .s_signed(s_signed), .s_user(s_user), .m_valid(m_valid),
    .m_ready(m_ready), .m_bin(m_bin), .m_mag(m_mag), .m_zero(m_zero), .m_user(m_user));

  hog_orient_bin #(.DATA_W(DATA_W), .QN(14), .USER_W(USER_W)) u_dut14 (
    .aclk(aclk), .arest(arest), .s_valid(s_valid), .s_ready(s_ready14), .s_dx(s_dx),
    .s_dy(s_dy), .s_signed(s_signed), .s_user(s_user), .m_valid(m_valid14),
    .m_ready(m_ready), .m_bin(m_bin14), .m_mag(m_mag14), .m_zero(m_zero14),
    .m_user(m_user14));

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int refCoef(input int c14, input int qn);
    if (qn == 14) return c14;
    return (c14 + (1 << (13 - qn))) >> (14 - qn);
  endfunction

  // Nearest of the 20-degree bin centres, found by scoring each centre within the quadrant.
  function automatic int refBin(input int dx, input int dy, input bit sgnMode, input int qn);
    int c14 [5] = '{16384, 15396, 12551, 8192, 2845};
    int s14 [5] = '{0, 5604, 10531, 14189, 16135};
    longint ax, ay, d, best;
    int q, kb, b;
    if (dx == 0 && dy == 0) return 0;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    if (dy >= 0) q = (dx >= 0) ? 0 : 1;
    else         q = (dx <= 0) ? 2 : 3;
    best = -1;
    kb = 0;
    for (int k = 0; k < 5; k++) begin
      d = ax * refCoef(c14[k], qn) + ay * refCoef(s14[k], qn);
      if (d > best || (d == best && (q == 1 || q == 3))) begin
        best = d;
        kb = k;
      end
    end
    case (q)
      0: b = kb;
      1: b = 9 - kb;
      2: b = 9 + kb;
      default: b = 18 - kb;
    endcase
    if (b == 18) b = 0;
    if (!sgnMode) b = b % 9;
    return b;
  endfunction

  always @(negedge aclk) begin
    case (readyMode)
      0: m_ready = 1'b1;
      1: begin
        m_ready = (patCnt % 5 == 0) || (patCnt % 5 == 3);
        patCnt++;
      end
      2: m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Drive one beat, hold it until accepted, then push what the model expects from it.
  task automatic applyStimulus(input int dx, input int dy, input bit sgn, input int expBin,
                               input string tag);
    exp_t e;
    int guard;
    @(negedge aclk);
    s_valid  = 1'b1;
    s_dx     = DATA_W'(dx);
    s_dy     = DATA_W'(dy);
    s_signed = sgn;
    s_user   = USER_W'(userCnt);
    #1;
    guard = 0;
    while (!s_ready && guard < 1000) begin
      @(negedge aclk);
      #1;
      guard++;
    end
    if (!s_ready) begin
      $display("[TB] FAIL accept_%s: got stalled expected accepted", tag);
      $fatal(1, "[TB] input never accepted");
    end
    e.bin8   = (expBin >= 0) ? expBin : refBin(dx, dy, sgn, 8);
    e.bin14  = (expBin >= 0) ? expBin : refBin(dx, dy, sgn, 14);
    e.mag    = ((dx < 0) ? -dx : dx) + ((dy < 0) ? -dy : dy);
    e.zero   = (dx == 0 && dy == 0) ? 1 : 0;
    e.user   = userCnt % (1 << USER_W);
    e.cyc    = cyc;
    e.chkLat = (readyMode == 0);
    e.tag    = tag;
    sbq.push_back(e);
    userCnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      s_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input string tag);
    idle(1);
    for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge aclk);
    checkOutput({"drain_", tag}, sbq.size(), 0);
    sbq.delete();
  endtask

  always @(negedge aclk) begin
    #2;
    if (started && !arest) begin
      checkOutput("s_ready_en", s_ready, !m_valid || m_ready);
      checkOutput("valid_qn14", m_valid14, m_valid);
      if (haveSnap) begin
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_bin", m_bin, snapBin);
        checkOutput("stall_mag", m_mag, snapMag);
        checkOutput("stall_zero", m_zero, snapZero);
        checkOutput("stall_user", m_user, snapUser);
      end
      haveSnap = m_valid && !m_ready;
      snapBin  = m_bin;
      snapMag  = m_mag;
      snapZero = m_zero;
      snapUser = m_user;
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_beat", m_valid, 0);
        end else begin
          monE = sbq.pop_front();
          checkOutput({monE.tag, "_bin8"}, m_bin, monE.bin8);
          checkOutput({monE.tag, "_bin14"}, m_bin14, monE.bin14);
          checkOutput({monE.tag, "_mag"}, m_mag, monE.mag);
          checkOutput({monE.tag, "_zero"}, m_zero, monE.zero);
          checkOutput({monE.tag, "_user"}, m_user, monE.user);
          if (monE.chkLat) checkOutput({monE.tag, "_latency"}, cyc - monE.cyc, 4);
        end
      end
    end
  end

  initial begin
    real a;
    int  rdx, rdy;
    arest = 1'b1;
    s_valid = 1'b0; s_dx = '0; s_dy = '0; s_signed = 1'b0; s_user = '0;
    m_ready = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_bin", m_bin, 0);
    checkOutput("rst_m_mag", m_mag, 0);
    checkOutput("rst_m_zero", m_zero, 0);
    checkOutput("rst_m_user", m_user, 0);
    @(negedge aclk);
    arest = 1'b0;
    started = 1'b1;

    $display("[TB] directed axes, wrap, diagonal, extremes");
    applyStimulus(100, 0, 1, 0, "ax0");
    applyStimulus(0, 50, 1, 4, "ax90");
    applyStimulus(-100, 0, 1, 9, "ax180");
    applyStimulus(0, -50, 1, 13, "ax270");
    applyStimulus(100, -1, 1, 0, "wrap");
    applyStimulus(-100, -100, 1, 11, "diag_s");
    applyStimulus(-100, -100, 0, 2, "diag_u");
    applyStimulus(-94, 34, 1, 8, "deg160");
    applyStimulus(-32768, -32768, 1, 11, "extreme");
    applyStimulus(0, 0, 1, 0, "zero");
    waitDrain("directed");

    $display("[TB] mode interleave");
    for (int i = 0; i < 8; i++) applyStimulus(-100, -100, (i % 2 == 0), (i % 2 == 0) ? 11 : 2, "ilv");
    waitDrain("interleave");

    $display("[TB] backpressure patterns");
    readyMode = 1;
    for (int i = 0; i < 20; i++)
      applyStimulus($signed(16'($urandom)), $signed(16'($urandom)), 1'($urandom), -1, "bp_pat");
    waitDrain("bp_pat");
    readyMode = 2;
    for (int i = 0; i < 20; i++)
      applyStimulus($signed(16'($urandom)), $signed(16'($urandom)), 1'($urandom), -1, "bp_tog");
    waitDrain("bp_tog");
    readyMode = 3;
    for (int i = 0; i < 150; i++) begin
      rdx = (i % 10 == 0) ? -32768 : $signed(16'($urandom));
      rdy = (i % 7 == 0) ? 0 : $signed(16'($urandom));
      applyStimulus(rdx, rdy, 1'($urandom), -1, "rnd");
      if (i % 13 == 0) idle(2);
    end
    waitDrain("rnd");
    readyMode = 0;

    $display("[TB] reset with beats in flight");
    for (int i = 0; i < 3; i++) applyStimulus(100 + i, 7, 1, -1, "doomed");
    @(negedge aclk);
    s_valid = 1'b0;
    #3;
    arest = 1'b1;
    #1;
    checkOutput("rst_flight_m_valid", m_valid, 0);
    sbq.delete();
    repeat (2) @(negedge aclk);
    arest = 1'b0;
    idle(8);
    applyStimulus(0, 50, 1, 4, "post_rst");
    waitDrain("post_rst");

    $display("[TB] angle sweep radius 1000");
    for (int i = 0; i < 3600; i++) begin
      a = i * 0.1 * 3.14159265358979 / 180.0;
      rdx = int'(1000.0 * $cos(a));
      rdy = int'(1000.0 * $sin(a));
      applyStimulus(rdx, rdy, 1, -1, "sweep");
    end
    waitDrain("sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
